// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit patterns (seg7..seg1 -> bits 6..0),
// monitor FSM state encodings and the mod-10 successor helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111100;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1100111;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [3:0] seg7_succ(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the seven-segment encoder: pattern -> {valid, digit}.
// Unknown patterns (including all-off) decode to valid=0, digit=0.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        digit = 4'd0;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_monitor.sv
// Receive-side checker for the seven-segment seconds bus: synchronise, deglitch,
// decode, then verify the +1 mod 10 sequence and the step interval.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned PERIOD        = 16_000_001,
    parameter int unsigned TOL           = 2,
    parameter int unsigned CNT_W         = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       clear_errors,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       new_digit,
    output logic       invalid_pattern,
    output logic       seq_error,
    output logic       period_error,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam int unsigned      STAB_W     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W:0]    PER_LO    = (CNT_W + 1)'(PERIOD - TOL);
    localparam logic [CNT_W:0]    PER_HI    = (CNT_W + 1)'(PERIOD + TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT_M1 = CNT_W'(PERIOD + TOL - 1);

    logic [6:0]        sync1_q, sync2_q, cand_q, accepted_q;
    logic [STAB_W-1:0] stab_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W:0]    measured;
    state_t            state_q, state_d;
    logic              dec_valid, is_succ, accept;
    logic [3:0]        dec_digit;
    logic              invalid_d, seq_d, period_d, err_d;
    logic [7:0]        err_next;

    seg7_decode u_decode (
        .pattern (cand_q),
        .valid   (dec_valid),
        .digit   (dec_digit)
    );

    assign accept   = (stab_q == STAB_MAX) && (cand_q != accepted_q);
    assign measured = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign is_succ  = dec_valid && (dec_digit == seg7_succ(digit));
    assign locked   = (state_q == LOCKED);

    always_comb begin
        state_d   = state_q;
        invalid_d = 1'b0;
        seq_d     = 1'b0;
        period_d  = 1'b0;
        case (state_q)
            SEARCH: begin
                if (accept) begin
                    if (dec_valid) state_d = SYNC;
                    else           invalid_d = 1'b1;
                end
            end
            SYNC: begin
                if (accept) begin
                    if (!dec_valid) begin
                        invalid_d = 1'b1;
                        state_d   = SEARCH;
                    end else if (is_succ) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (!dec_valid) begin
                        invalid_d = 1'b1;
                        state_d   = SEARCH;
                    end else if (!is_succ) begin
                        seq_d   = 1'b1;
                        state_d = SYNC;
                    end else if (measured < PER_LO || measured > PER_HI) begin
                        period_d = 1'b1;
                    end
                end else if (cnt_q == TIMEOUT_M1) begin
                    // Counter reaches PERIOD+TOL on this edge with no step seen.
                    period_d = 1'b1;
                    state_d  = SYNC;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign err_d = invalid_d | seq_d | period_d;

    always_comb begin
        err_next = err_count;
        if (clear_errors)                  err_next = err_d ? 8'd1 : 8'd0;
        else if (err_d && err_count != 8'hFF) err_next = err_count + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q         <= 7'h00;
            sync2_q         <= 7'h00;
            cand_q          <= 7'h00;
            stab_q          <= '0;
            accepted_q      <= 7'h00;
            cnt_q           <= '0;
            state_q         <= SEARCH;
            digit           <= 4'd0;
            digit_valid     <= 1'b0;
            new_digit       <= 1'b0;
            invalid_pattern <= 1'b0;
            seq_error       <= 1'b0;
            period_error    <= 1'b0;
            err_count       <= 8'd0;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                stab_q <= '0;
            end else if (stab_q != STAB_MAX) begin
                stab_q <= stab_q + STAB_W'(1);
            end
            if (accept) begin
                accepted_q  <= cand_q;
                digit       <= dec_digit;
                digit_valid <= dec_valid;
                cnt_q       <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            new_digit       <= accept;
            invalid_pattern <= invalid_d;
            seq_error       <= seq_d;
            period_error    <= period_d;
            state_q         <= state_d;
            err_count       <= err_next;
        end
    end

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed self-checking bench for seg7_monitor (STABLE_CYCLES=4, PERIOD=101, TOL=2).
module tb_seg7_monitor;
    import seg7_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       clear_errors;
    logic [3:0] digit;
    logic       digit_valid, new_digit, invalid_pattern, seq_error, period_error, locked;
    logic [7:0] err_count;
    logic [6:0] pats [10];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seg7_monitor #(
        .STABLE_CYCLES (4),
        .PERIOD        (101),
        .TOL           (2),
        .CNT_W         (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .seg_in          (seg_in),
        .clear_errors    (clear_errors),
        .digit           (digit),
        .digit_valid     (digit_valid),
        .new_digit       (new_digit),
        .invalid_pattern (invalid_pattern),
        .seq_error       (seq_error),
        .period_error    (period_error),
        .locked          (locked),
        .err_count       (err_count)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {28'd0, new_digit, invalid_pattern, seq_error, period_error}, 32'd0);
    endtask

    // Present a pattern, check the accept edge 7 cycles later, return 'gap' cycles after drive.
    task automatic step(input logic [6:0] pat, input int gap, input logic [3:0] e_digit,
                        input logic e_valid, input logic e_locked, input logic e_inv,
                        input logic e_seq, input logic e_per, input logic [7:0] e_err);
        seg_in = pat;
        tick(6);
        check("new_digit_early", new_digit, 1'b0);
        tick(1);
        check("new_digit", new_digit, 1'b1);
        check("digit", digit, e_digit);
        check("digit_valid", digit_valid, e_valid);
        check("locked", locked, e_locked);
        check("pulses", {invalid_pattern, seq_error, period_error}, {e_inv, e_seq, e_per});
        check("err_count", err_count, e_err);
        tick(1);
        check_quiet("pulse_width");
        tick(gap - 8);
    endtask

    initial begin
        pats[0] = SEG_0; pats[1] = SEG_1; pats[2] = SEG_2; pats[3] = SEG_3; pats[4] = SEG_4;
        pats[5] = SEG_5; pats[6] = SEG_6; pats[7] = SEG_7; pats[8] = SEG_8; pats[9] = SEG_9;
        reset        = 1'b1;
        seg_in       = 7'h00;
        clear_errors = 1'b0;
        tick(3);
        check("rst_digit", {digit_valid, digit}, 5'd0);
        check("rst_locked", locked, 1'b0);
        check("rst_err", err_count, 8'd0);
        check_quiet("rst_pulses");
        reset = 1'b0;
        tick(2);

        // Clean 0..9,0 stream, continuing to 3.
        step(pats[0], 101, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int d = 1; d <= 9; d++)
            step(pats[d], 101, 4'(d), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(pats[0], 101, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(pats[1], 101, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(pats[2], 101, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(pats[3], 8, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // 3-cycle glitch to 4 must be rejected.
        seg_in = pats[4];
        tick(3);
        seg_in = pats[3];
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check_quiet("glitch_quiet");
        end
        check("glitch_digit", digit, 4'd3);
        tick(78);

        step(pats[4], 101, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(pats[5], 101, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        // Skip from 5 to 7.
        step(pats[7], 101, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        step(pats[8], 8, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

        // Timeout: no step by accept+103.
        tick(101);
        check("pre_timeout", {period_error, locked}, 2'b01);
        tick(1);
        check("timeout_pulse", {period_error, locked}, 2'b10);
        check("timeout_err", err_count, 8'd2);
        step(pats[9], 98, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        // Short interval of 98 cycles.
        step(pats[0], 101, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3);

        // All-off pattern, then saturate the error counter.
        step(7'h00, 8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        for (int i = 0; i < 300; i++) begin
            seg_in = (i % 2 == 0) ? 7'h01 : 7'h00;
            tick(7);
        end
        check("sat_err", err_count, 8'd255);
        check("sat_inv", {invalid_pattern, locked}, 2'b10);

        // Relock, then reset mid-interval and mid-filter.
        step(pats[0], 101, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
        step(pats[1], 20, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
        seg_in = pats[2];
        tick(4);
        reset = 1'b1;
        #1;
        check("mid_rst_digit", {digit_valid, digit}, 5'd0);
        check("mid_rst_lock_err", {locked, err_count}, 9'd0);
        seg_in = 7'h00;
        tick(3);
        reset = 1'b0;
        tick(10);
        check_quiet("post_rst_quiet");
        step(pats[2], 101, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(pats[3], 8, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Invalid while locked, then clear coinciding with another error.
        step(7'h00, 8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        seg_in = 7'h01;
        tick(6);
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        check("clear_with_err", {invalid_pattern, err_count}, {1'b1, 8'd1});
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        check("clear_err", err_count, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
